// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared constants and state encoding for the BCD-to-binary converter
package dec_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int VAL_W      = 17;
    localparam int ACC_W      = 20;
    localparam int VAL_MAX    = 131071;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/mul10_add.sv
// rtl/mul10_add.sv - combinational acc*10 + digit built from two shifts and adds
module mul10_add
    import dec_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] result
);

    assign result = (acc << 3) + (acc << 1) + ACC_W'(digit);

endmodule

// File: rtl/dec_to_bin.sv
// rtl/dec_to_bin.sv - sequential packed-BCD to binary converter, one digit per clock
// Build option: DEC_TO_BIN_SATURATE_EN clamps val to all ones on overflow instead of wrapping.
module dec_to_bin #(
    parameter int NUM_DIGITS = dec_pkg::NUM_DIGITS,
    parameter int VAL_W      = dec_pkg::VAL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    done,
    output logic [VAL_W-1:0]        val,
    output logic                    overflow,
    output logic                    invalid
);
    import dec_pkg::*;

    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [ACC_W-1:0] OVF_LIMIT = ACC_W'((64'd1 << VAL_W) - 64'd1);

    state_t             state;
    logic [DIG_W-1:0]   dig_sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   next_acc;
    logic [IDX_W-1:0]   idx;
    logic               inv_cap;
    logic [3:0]         nibble;
    logic               inv_final;

    assign nibble    = dig_sr[DIG_W-1 -: 4];
    assign inv_final = inv_cap | (nibble > 4'd9);

    mul10_add u_mul10_add (
        .acc    (acc),
        .digit  (nibble),
        .result (next_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dig_sr   <= '0;
            acc      <= '0;
            idx      <= '0;
            inv_cap  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            val      <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dig_sr  <= digits;
                        acc     <= '0;
                        idx     <= IDX_W'(NUM_DIGITS - 1);
                        inv_cap <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc     <= next_acc;
                    dig_sr  <= dig_sr << 4;
                    inv_cap <= inv_final;
                    idx     <= idx - IDX_W'(1);
                    // Final digit: publish the result from the value being accumulated this edge.
                    if (idx == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (inv_final) begin
                            invalid  <= 1'b1;
                            overflow <= 1'b0;
                            val      <= '0;
                        end else if (next_acc > OVF_LIMIT) begin
                            invalid  <= 1'b0;
                            overflow <= 1'b1;
`ifdef DEC_TO_BIN_SATURATE_EN
                            val      <= '1;
`else
                            val      <= next_acc[VAL_W-1:0];
`endif
                        end else begin
                            invalid  <= 1'b0;
                            overflow <= 1'b0;
                            val      <= next_acc[VAL_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
